// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM encoding, line-format codes and oversampling constants.
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int SAMPLE_MID = 8;

    typedef logic [2:0] rx_state_t;

    localparam rx_state_t RX_IDLE      = 3'd0;
    localparam rx_state_t RX_START     = 3'd1;
    localparam rx_state_t RX_DATA      = 3'd2;
    localparam rx_state_t RX_PARITY    = 3'd3;
    localparam rx_state_t RX_STOP1     = 3'd4;
    localparam rx_state_t RX_STOP2     = 3'd5;
    localparam rx_state_t RX_WAIT_IDLE = 3'd6;

    // parity_mode 2'b00 and 2'b11 both mean no parity bit
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    // data_bits field: 00=5 .. 11=8 data bits
    function automatic logic [3:0] data_len(input logic [1:0] data_bits);
        return 4'd5 + {2'b00, data_bits};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-bit pointers; head is presented combinationally and reads zero when empty.
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LW-1:0]    level_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [LW-1:0]    wr_q, rd_q;
    logic             do_push, do_pop;

    assign level_o = wr_q - rd_q;
    assign full_o  = (level_o == LW'(DEPTH));
    assign empty_o = (wr_q == rd_q);

    // A push into a full FIFO is only legal when the head leaves in the same cycle
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + LW'(1);
            if (do_pop)  rd_q <= rd_q + LW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
    end

    assign rdata_o = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

endmodule

// File: rtl/uart_rx_core.sv
// UART receive engine: rxd synchroniser, oversample tick, majority-vote framing FSM,
// RX FIFO with watermark and sticky framing/parity/overrun flags.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_WIDTH  = 16,
    localparam int LVL_WIDTH = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 CLK_I,
    input  logic                 RST_I,
    input  logic                 rxd,
    input  logic                 rx_en,
    input  logic [DIV_WIDTH-1:0] div,
    input  logic [1:0]           data_bits,
    input  logic [1:0]           parity_mode,
    input  logic                 nstop,
    input  logic [LVL_WIDTH-1:0] wm_level,
    input  logic                 rd_ready,
    input  logic                 err_clr,
    output logic [7:0]           rd_data,
    output logic                 rd_valid,
    output logic                 full,
    output logic [LVL_WIDTH-1:0] level,
    output logic                 rxwm,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic [2:0]           dbg_state_o
);

    localparam logic [3:0] PH_A    = 4'(SAMPLE_MID - 1);
    localparam logic [3:0] PH_B    = 4'(SAMPLE_MID);
    localparam logic [3:0] PH_C    = 4'(SAMPLE_MID + 1);
    localparam logic [3:0] PH_LAST = 4'(OVERSAMPLE - 1);

    logic                 sync1_q, sync2_q, prev_q, rxd_s, fall;
    logic [DIV_WIDTH-1:0] cnt_q;
    logic                 tick;

    // Synchroniser resets to the idle-high level so reset release never looks like a start edge
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= rxd;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign rxd_s = sync2_q;
    assign fall  = prev_q & ~sync2_q;

    assign tick = (cnt_q == '0);

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I)     cnt_q <= div;
        else if (tick) cnt_q <= div;
        else           cnt_q <= cnt_q - DIV_WIDTH'(1);
    end

    rx_state_t  state_q, state_d;
    logic [3:0] phase_q, phase_d;
    logic [1:0] samp_q, samp_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       par_bad_q, par_bad_d;
    logic [3:0] n_bits;
    logic [7:0] rx_char;
    logic       par_en, maj, done, frame_bad;

    assign n_bits  = data_len(data_bits);
    assign rx_char = shift_q >> (4'd8 - n_bits);
    assign par_en  = (parity_mode == PAR_EVEN) || (parity_mode == PAR_ODD);
    assign maj     = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxd_s) | (samp_q[1] & rxd_s);

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        samp_d    = samp_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_bad_d = par_bad_q;
        done      = 1'b0;
        frame_bad = 1'b0;
        if (!rx_en) begin
            state_d = RX_IDLE;
        end else if (state_q == RX_IDLE) begin
            if (fall) begin
                state_d = RX_START;
                phase_d = '0;
            end
        end else if (state_q == RX_WAIT_IDLE) begin
            if (rxd_s) state_d = RX_IDLE;
        end else if (tick) begin
            phase_d = phase_q + 4'd1;
            if (phase_q == PH_A) samp_d[0] = rxd_s;
            if (phase_q == PH_B) samp_d[1] = rxd_s;
            case (state_q)
                RX_START: begin
                    if (phase_q == PH_C && maj) begin
                        state_d = RX_IDLE;
                    end else if (phase_q == PH_LAST) begin
                        state_d   = RX_DATA;
                        bit_cnt_d = '0;
                        par_bad_d = 1'b0;
                    end
                end
                RX_DATA: begin
                    if (phase_q == PH_C) shift_d = {maj, shift_q[7:1]};
                    if (phase_q == PH_LAST) begin
                        if ({1'b0, bit_cnt_q} == n_bits - 4'd1)
                            state_d = par_en ? RX_PARITY : RX_STOP1;
                        else
                            bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
                RX_PARITY: begin
                    if (phase_q == PH_C)
                        par_bad_d = ((^rx_char) ^ maj) != (parity_mode == PAR_ODD);
                    else if (phase_q == PH_LAST)
                        state_d = RX_STOP1;
                end
                RX_STOP1, RX_STOP2: begin
                    if (phase_q == PH_C) begin
                        if (!maj) begin
                            state_d   = RX_WAIT_IDLE;
                            done      = 1'b1;
                            frame_bad = 1'b1;
                        end else if (!(state_q == RX_STOP1 && nstop)) begin
                            state_d = RX_IDLE;
                            done    = 1'b1;
                        end
                    end else if (phase_q == PH_LAST) begin
                        state_d = RX_STOP2;
                    end
                end
                default: state_d = RX_IDLE;
            endcase
        end
    end

    logic       push_q, perr_ev_q, ferr_ev_q;
    logic [7:0] char_q;

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_q   <= RX_IDLE;
            phase_q   <= '0;
            samp_q    <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_bad_q <= 1'b0;
            push_q    <= 1'b0;
            perr_ev_q <= 1'b0;
            ferr_ev_q <= 1'b0;
            char_q    <= '0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            samp_q    <= samp_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_bad_q <= par_bad_d;
            push_q    <= done & ~frame_bad & ~par_bad_q;
            perr_ev_q <= done & par_bad_q;
            ferr_ev_q <= frame_bad;
            char_q    <= rx_char;
        end
    end

    logic fifo_empty, pop, fifo_push, ovr_ev;
    logic frame_err_q, parity_err_q, overrun_q;

    assign pop       = rd_valid & rd_ready;
    assign fifo_push = push_q & (~full | pop);
    assign ovr_ev    = push_q & full & ~pop;

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk_i   (CLK_I),
        .rst_i   (RST_I),
        .push_i  (fifo_push),
        .wdata_i (char_q),
        .pop_i   (pop),
        .rdata_o (rd_data),
        .full_o  (full),
        .empty_o (fifo_empty),
        .level_o (level)
    );

    // A new error event outranks err_clr in the same cycle
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            frame_err_q  <= ferr_ev_q | (frame_err_q & ~err_clr);
            parity_err_q <= perr_ev_q | (parity_err_q & ~err_clr);
            overrun_q    <= ovr_ev | (overrun_q & ~err_clr);
        end
    end

    assign rd_valid    = ~fifo_empty;
    assign rxwm        = (level > wm_level);
    assign frame_err   = frame_err_q;
    assign parity_err  = parity_err_q;
    assign overrun     = overrun_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Randomised bench for uart_rx_core: serialises characters onto rxd and compares the
// FIFO/flag view against a character-level queue model.
module tb_uart_rx_core;

    localparam int DEPTH = 8;
    localparam int DW    = 16;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          rxd, rx_en, nstop, rd_ready, err_clr;
    logic [DW-1:0] div;
    logic [1:0]    data_bits, parity_mode;
    logic [LW-1:0] wm_level;
    logic [7:0]    rd_data;
    logic          rd_valid, full, rxwm, frame_err, parity_err, overrun;
    logic [LW-1:0] level;
    logic [2:0]    dbg_state;

    uart_rx_core #(.FIFO_DEPTH(DEPTH), .DIV_WIDTH(DW)) dut (
        .CLK_I       (clk),
        .RST_I       (rst),
        .rxd         (rxd),
        .rx_en       (rx_en),
        .div         (div),
        .data_bits   (data_bits),
        .parity_mode (parity_mode),
        .nstop       (nstop),
        .wm_level    (wm_level),
        .rd_ready    (rd_ready),
        .err_clr     (err_clr),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .full        (full),
        .level       (level),
        .rxwm        (rxwm),
        .frame_err   (frame_err),
        .parity_err  (parity_err),
        .overrun     (overrun),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int         n_chk = 0;
    int         n_err = 0;
    int         lat;
    logic [7:0] exp_q[$];
    logic       m_ferr, m_perr, m_ovr;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic b);
        rxd = b;
        repeat (16 * (int'(div) + 1)) @(negedge clk);
    endtask

    function automatic logic par_on();
        return (parity_mode == 2'b01) || (parity_mode == 2'b10);
    endfunction

    function automatic logic [7:0] mask_char(input logic [7:0] d);
        logic [7:0] m;
        m = 8'hFF >> (3 - int'(data_bits));
        return d & m;
    endfunction

    task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic bad_stop);
        logic [7:0] dm;
        logic       p;
        dm = mask_char(d);
        drive_bit(1'b0);
        for (int i = 0; i < int'(data_bits) + 5; i++) drive_bit(dm[i]);
        if (par_on()) begin
            p = (^dm) ^ (parity_mode == 2'b10);
            drive_bit(p ^ bad_par);
        end
        drive_bit(~bad_stop);
        if (nstop) drive_bit(1'b1);
        rxd = 1'b1;
    endtask

    task automatic model_char(input logic [7:0] d, input logic bad_par, input logic bad_stop);
        if (bad_stop)                  m_ferr = 1'b1;
        else if (bad_par && par_on())  m_perr = 1'b1;
        else if (exp_q.size() == DEPTH) m_ovr = 1'b1;
        else                           exp_q.push_back(mask_char(d));
    endtask

    task automatic check_state(input string tag);
        logic [7:0] head;
        head = 8'h00;
        if (exp_q.size() != 0) head = exp_q[0];
        check_eq({tag, "_level"},  32'(level),  32'(exp_q.size()));
        check_eq({tag, "_valid"},  32'(rd_valid), 32'(exp_q.size() != 0));
        check_eq({tag, "_full"},   32'(full),   32'(exp_q.size() == DEPTH));
        check_eq({tag, "_rxwm"},   32'(rxwm),   32'(exp_q.size() > int'(wm_level)));
        check_eq({tag, "_data"},   32'(rd_data), 32'(head));
        check_eq({tag, "_ferr"},   32'(frame_err),  32'(m_ferr));
        check_eq({tag, "_perr"},   32'(parity_err), 32'(m_perr));
        check_eq({tag, "_ovr"},    32'(overrun),    32'(m_ovr));
    endtask

    task automatic send_and_check(input string tag, input logic [7:0] d, input logic bp, input logic bs);
        send_frame(d, bp, bs);
        model_char(d, bp, bs);
        idle_cycles(32 * (int'(div) + 1));
        check_state(tag);
    endtask

    task automatic pop_one(input string tag);
        logic [7:0] head;
        head = 8'h00;
        if (exp_q.size() != 0) head = exp_q[0];
        check_eq({tag, "_pop_valid"}, 32'(rd_valid), 32'(exp_q.size() != 0));
        check_eq({tag, "_pop_data"},  32'(rd_data),  32'(head));
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
    endtask

    task automatic drain(input string tag);
        while (exp_q.size() != 0) pop_one(tag);
        check_state({tag, "_drained"});
    endtask

    task automatic clear_errs(input string tag);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        m_ferr = 1'b0;
        m_perr = 1'b0;
        m_ovr  = 1'b0;
        check_state(tag);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_data"},  32'(rd_data), 0);
        check_eq({tag, "_valid"}, 32'(rd_valid), 0);
        check_eq({tag, "_full"},  32'(full), 0);
        check_eq({tag, "_level"}, 32'(level), 0);
        check_eq({tag, "_rxwm"},  32'(rxwm), 0);
        check_eq({tag, "_ferr"},  32'(frame_err), 0);
        check_eq({tag, "_perr"},  32'(parity_err), 0);
        check_eq({tag, "_ovr"},   32'(overrun), 0);
        check_eq({tag, "_state"}, 32'(dbg_state), 0);
    endtask

    initial begin
        rst = 1'b1; rxd = 1'b1; rx_en = 1'b1; div = '0;
        data_bits = 2'b11; parity_mode = 2'b00; nstop = 1'b0;
        wm_level = LW'(3); rd_ready = 1'b0; err_clr = 1'b0;
        m_ferr = 1'b0; m_perr = 1'b0; m_ovr = 1'b0;
        #1;
        check_all_zero("reset");
        idle_cycles(3);
        rst = 1'b0;
        idle_cycles(5);
        check_state("post_reset");

        // 8N1 at div=0: rd_valid must appear around the end of the stop bit
        lat = 400;
        fork
            send_frame(8'hA5, 1'b0, 1'b0);
            begin
                for (int k = 0; k < 400; k++) begin
                    @(negedge clk);
                    if (rd_valid) begin
                        lat = k;
                        break;
                    end
                end
            end
        join
        check_eq("a5_latency_in_window", 32'(lat >= 148 && lat <= 163), 1);
        model_char(8'hA5, 1'b0, 1'b0);
        idle_cycles(32);
        check_state("a5");
        drain("a5");

        // 5 data bits, odd parity, two stop bits
        data_bits = 2'b00; parity_mode = 2'b10; nstop = 1'b1;
        send_and_check("p13_good", 8'h13, 1'b0, 1'b0);
        send_and_check("p13_bad", 8'h13, 1'b1, 1'b0);
        clear_errs("p13_clr");
        drain("p13");

        // Short glitch must be rejected as a false start
        data_bits = 2'b11; parity_mode = 2'b00; nstop = 1'b0;
        rxd = 1'b0;
        idle_cycles(4);
        check_eq("glitch_in_start", 32'(dbg_state), 1);
        idle_cycles(2);
        rxd = 1'b1;
        idle_cycles(30);
        check_eq("glitch_back_idle", 32'(dbg_state), 0);
        check_state("glitch");

        // Low stop bit: framing error, receiver parks until the line returns high
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(8'h3C >> i);
        drive_bit(1'b0);
        idle_cycles(20);
        m_ferr = 1'b1;
        check_eq("ferr_wait_idle", 32'(dbg_state), 6);
        check_state("ferr");
        rxd = 1'b1;
        idle_cycles(10);
        check_eq("ferr_released", 32'(dbg_state), 0);
        clear_errs("ferr_clr");

        // Fill past capacity: watermark, full, overrun, then ordered drain
        wm_level = LW'(3);
        for (int i = 0; i < 9; i++) send_and_check($sformatf("fill%0d", i), 8'(i), 1'b0, 1'b0);
        drain("fill");
        clear_errs("fill_clr");

        // Push and pop land on the same edge while full
        for (int i = 0; i < DEPTH; i++) begin
            send_frame(8'(8'h80 + i), 1'b0, 1'b0);
            model_char(8'(8'h80 + i), 1'b0, 1'b0);
            idle_cycles(32);
        end
        check_state("collide_pre");
        fork
            send_frame(8'hC3, 1'b0, 1'b0);
            begin
                repeat (lat) @(negedge clk);
                rd_ready = 1'b1;
                @(negedge clk);
                rd_ready = 1'b0;
            end
        join
        void'(exp_q.pop_front());
        model_char(8'hC3, 1'b0, 1'b0);
        idle_cycles(32);
        check_state("collide");
        drain("collide");

        // Drop rx_en in the middle of data bit 4
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(8'hF0 >> i);
        rxd = 1'b1;
        idle_cycles(8);
        rx_en = 1'b0;
        idle_cycles(2);
        check_eq("rxen_forced_idle", 32'(dbg_state), 0);
        idle_cycles(20);
        rx_en = 1'b1;
        idle_cycles(20);
        check_state("rxen_nothing");
        send_and_check("rxen_5a", 8'h5A, 1'b0, 1'b0);
        drain("rxen");

        // Random formats, rates, errors, pops and clears
        for (int it = 0; it < 40; it++) begin
            int         e;
            logic [7:0] d;
            div         = DW'($urandom_range(0, 2));
            data_bits   = 2'($urandom_range(0, 3));
            parity_mode = 2'($urandom_range(0, 3));
            nstop       = 1'($urandom_range(0, 1));
            wm_level    = LW'($urandom_range(0, DEPTH));
            d           = 8'($urandom_range(0, 255));
            e           = $urandom_range(0, 9);
            send_and_check($sformatf("rnd%0d", it), d, e == 0, e == 1);
            for (int p = $urandom_range(0, 2); p > 0; p--) pop_one($sformatf("rnd%0d", it));
            if ($urandom_range(0, 5) == 0) clear_errs($sformatf("rnd%0d_clr", it));
        end

        // Asynchronous reset in the middle of a frame with state held
        div = '0; data_bits = 2'b11; parity_mode = 2'b00; nstop = 1'b0;
        send_and_check("pre_rst", 8'h77, 1'b0, 1'b0);
        rxd = 1'b0;
        idle_cycles(40);
        rst = 1'b1;
        #1;
        check_all_zero("mid_rst");
        exp_q.delete();
        m_ferr = 1'b0; m_perr = 1'b0; m_ovr = 1'b0;
        rxd = 1'b1;
        idle_cycles(3);
        rst = 1'b0;
        idle_cycles(5);
        send_and_check("post_rst", 8'h2E, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
Parametrised UART receive engine, successor to the fixed 8-bit 16x receiver inside the current uart peripheral.
- Adds runtime-selectable data width (5..8), parity (none/even/odd), 1 or 2 stop bits and majority-vote sampling.
- Adds a depth-parametrised RX FIFO with watermark, plus sticky framing, parity and overrun flags.
- Sits between the rxd pin and the Wishbone register file, which drives config/pop and reads status.

Parameters:
FIFO_DEPTH, 8, RX FIFO entries; power of 2, >= 2
DIV_WIDTH, 16, width of oversample divisor
LVL_WIDTH, $clog2(FIFO_DEPTH)+1, occupancy/watermark width (derived, not overridable)

Ports:
CLK_I  in  1  system clock
RST_I  in  1  reset, asynchronous, active-high
rxd  in  1  serial input, asynchronous, idle high
rx_en  in  1  receiver enable
div  in  DIV_WIDTH  oversample tick period = div+1 clocks (16 ticks per bit)
data_bits  in  2  00=5, 01=6, 10=7, 11=8 data bits
parity_mode  in  2  00 none, 01 even, 10 odd, 11 treated as none
nstop  in  1  0 = one stop bit, 1 = two stop bits
wm_level  in  LVL_WIDTH  rx watermark threshold
rd_ready  in  1  pop request
err_clr  in  1  clear sticky error flags
rd_data  out  8  FIFO head; unused upper bits zero
rd_valid  out  1  FIFO not empty
full  out  1  FIFO full
level  out  LVL_WIDTH  FIFO occupancy
rxwm  out  1  level > wm_level
frame_err  out  1  sticky: stop bit sampled low
parity_err  out  1  sticky: parity mismatch
overrun  out  1  sticky: char arrived with FIFO full

Behaviour:
- Reset: every output 0, FSM Idle, FIFO pointers 0, tick counter loaded with div.
- rxd passes a 2-FF synchroniser; all sampling uses the synchronised value.
- Tick generator: down-counter; tick when count is 0, then reload div. div=0 gives a tick every cycle. A div change takes effect at the next reload.
- Bit sampling: 4-bit tick phase counter per bit. Samples at phases 7, 8 and 9; bit value = majority of the three.
- FSM states and transitions:
  - Idle -> Start on a synchronised falling edge; phase cleared.
  - Start: majority high at phase 9 = false start, back to Idle. Otherwise go to Data at phase 15.
  - Data: shift LSB-first, data_bits+5 bits, then go to Parity (if enabled) or Stop1.
  - Parity: even = XOR(data, p) must be 0; odd = must be 1.
  - Stop1: evaluated at phase 9. On success go to Stop2 (if nstop) or Idle.
  - Stop2: checked the same way as Stop1.
  - WaitIdle: entered after a framing error; returns to Idle once the synchronised rxd is 1.
- Push: on the cycle after the last stop-bit decision, if no parity or framing error. rd_valid rises on the following cycle, 1 cycle later.
- Error characters: a character with a parity or framing error is discarded and the matching sticky flag is set.
- Overrun: a push while full and not popping drops the new character and sets overrun; FIFO contents are unchanged.
- Simultaneous push and pop when full: both are accepted and level is unchanged.
- Simultaneous push and pop when empty: the push is stored; rd_valid is 0 that cycle, so no pop occurs.
- Pop: when rd_valid && rd_ready, the read pointer advances. rd_data is the combinational head and is zero-extended.
- Pointers wrap modulo FIFO_DEPTH.
- err_clr: clears the sticky flags next cycle. A new error in the same cycle wins, and the flag stays 1.
- rx_en low: FSM forced to Idle next cycle and any partial character discarded. FIFO and flags are retained.
- Reset mid-frame: everything is cleared immediately (asynchronous), including the FIFO.

Decomposition:
- Shared package uart_pkg: rx state enum, parity mode constants, data_bits encoding, OVERSAMPLE=16, SAMPLE_MID=8.
- One sub-module sync_fifo (parameters DEPTH, WIDTH) exposing push, pop, full, empty and level; reused later for TX.
- Synchroniser, tick generator and FSM stay inline.

Test Plan:
- div=0, 8N1, send 0xA5 (bit period 16 clk) -> rd_valid high 2 (sync) + 1 cycles after the stop phase-9 tick; rd_data=0xA5; level=1; no flags.
- data_bits=00, parity odd, nstop=1, send 0x13 with correct parity -> rd_data=0x13. Repeat with flipped parity -> nothing pushed, parity_err=1. Pulse err_clr -> 0.
- Glitch rxd low for 6 ticks in Idle -> false start, FSM back to Idle, nothing pushed. Then send 0x3C with stop bit low -> frame_err=1, FSM in WaitIdle until rxd=1.
- FIFO_DEPTH=8, wm_level=3, send 9 chars 0x00..0x08 without popping:
  - rxwm rises when level=4.
  - full after 8 chars.
  - 9th char dropped, overrun=1.
  - Pops return 0x00..0x07 in order, wrapping correctly.
- Full FIFO with rd_ready held high while a char completes -> both operations occur, level stays 8, head advances, no overrun.
- Drop rx_en mid-data (bit 4), then re-enable and send 0x5A -> only 0x5A in FIFO. Assert RST_I mid-frame -> all outputs 0 immediately.
